// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU load or store of 1/2/4/8 bytes into a
// little-endian sequence of byte accesses on a byte-wide memory port, with
// a per-byte ack timeout and sign/zero extension of load results.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [63:0] Mem_Addr,
   input  logic [63:0] Write_Data,
   output logic [63:0] Read_Data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

   state_t         state_reg, state_next;
   logic           we_reg;
   logic           zext_reg;
   logic [1:0]     size_reg;
   logic [63:0]    addr_reg;
   logic [63:0]    wdata_reg;
   logic [63:0]    part_reg;
   logic [63:0]    read_data_reg;
   logic [2:0]     idx_reg;
   logic [WW-1:0]  wait_reg;
   logic           err_reg;

   logic [2:0]     last_idx;
   logic [63:0]    assembled;
   logic [63:0]    extended;
   logic           timed_out;

   assign timed_out = (state_reg == XFER) && !mem_ack && (wait_reg == WW'(TIMEOUT - 1));
   assign Read_Data = read_data_reg;

   // Partial load result with the byte arriving this cycle merged into its lane.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign assembled[gi*8 +: 8] = (idx_reg == 3'(gi)) ? mem_rdata : part_reg[gi*8 +: 8];
      end
   endgenerate

   // Index of the final byte and the extended load value for the latched size.
   always_comb begin
      last_idx = 3'd7;
      extended = assembled;
      case (size_reg)
         2'd0: begin
            last_idx = 3'd0;
            extended = zext_reg ? {56'd0, assembled[7:0]} : {{56{assembled[7]}}, assembled[7:0]};
         end
         2'd1: begin
            last_idx = 3'd1;
            extended = zext_reg ? {48'd0, assembled[15:0]} : {{48{assembled[15]}}, assembled[15:0]};
         end
         2'd2: begin
            last_idx = 3'd3;
            extended = zext_reg ? {32'd0, assembled[31:0]} : {{32{assembled[31]}}, assembled[31:0]};
         end
         default: begin
            last_idx = 3'd7;
            extended = assembled;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // Next-state decode and all port outputs; the memory port is quiet outside XFER.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 64'd0;
      mem_wdata  = 8'd0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = (MemRead != MemWrite) ? XFER : FINISH;
         end
         XFER: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = we_reg;
            mem_addr  = addr_reg + {61'd0, idx_reg};
            mem_wdata = wdata_reg[{idx_reg, 3'b000} +: 8];
            if ((mem_ack && idx_reg == last_idx) || timed_out) state_next = FINISH;
         end
         FINISH: begin
            busy       = 1'b1;
            done       = 1'b1;
            err        = err_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latching, byte stepping, wait counting and load result capture.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we_reg        <= 1'b0;
         zext_reg      <= 1'b0;
         size_reg      <= 2'd0;
         addr_reg      <= 64'd0;
         wdata_reg     <= 64'd0;
         part_reg      <= 64'd0;
         read_data_reg <= 64'd0;
         idx_reg       <= 3'd0;
         wait_reg      <= '0;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  we_reg    <= MemWrite;
                  zext_reg  <= funct3[2];
                  size_reg  <= funct3[1:0];
                  addr_reg  <= Mem_Addr;
                  wdata_reg <= Write_Data;
                  part_reg  <= 64'd0;
                  idx_reg   <= 3'd0;
                  wait_reg  <= '0;
                  err_reg   <= (MemRead == MemWrite);
               end
            end
            XFER: begin
               if (mem_ack) begin
                  part_reg <= assembled;
                  wait_reg <= '0;
                  if (idx_reg == last_idx) begin
                     if (!we_reg) read_data_reg <= extended;
                     err_reg <= 1'b0;
                  end else begin
                     idx_reg <= idx_reg + 3'd1;
                  end
               end else if (timed_out) begin
                  err_reg <= 1'b1;
               end else begin
                  wait_reg <= wait_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
